trap_sequencer: RTL

Multi-cycle controller that sequences interrupt entry and `mret` exit for the 3-stage RISC-V pipeline with CSRs. It replaces ad-hoc single-cycle interrupt flushing with a state machine. The sequencer waits for a precise retirement point, captures `mepc`/`mcause`, strobes the CSR file, redirects fetch and flushes the decode and memory/writeback stages. It sits beside the forwarding/flush logic. Its flush outputs are ORed into the pipeline register clears, and `pc_sel` drives the fetch PC mux.

---
 rtl/trap_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/trap_sequencer.sv
// trap_sequencer: multi-cycle interrupt entry / mret exit controller for the
// 3-stage pipeline. Waits for a precise retirement point, latches mepc/mcause,
// strobes the CSR file, redirects fetch and flushes DE/MW.
// Optional build macro TRAP_SEQ_TIMEOUT_EN: bounds DRAIN to DRAIN_MAX bubble
// cycles, after which the DE instruction's PC becomes mepc.
module trap_sequencer #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned DRAIN_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    input  logic        is_mret_mw,
    input  logic        mw_valid,
    input  logic [31:0] pc_mw,
    input  logic [31:0] pc_de,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        stall_f,
    output logic        flush_de,
    output logic        flush_mw,
    output logic [1:0]  pc_sel,
    output logic        csr_trap_we,
    output logic        csr_mret_we,
    output logic [31:0] mepc_out,
    output logic [31:0] mcause_out,
    output logic        trap_taken
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        ENTER,
        EXIT,
        GAP
    } state_t;

    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;
    localparam logic [3:0]  GAP_LOAD    = 4'(GAP_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  gap_cnt;
    logic        ext_pend;
    logic        irq_pend;

    assign ext_pend = ext_irq & mie_meie;
    assign irq_pend = mstatus_mie & (ext_pend | (timer_irq & mie_mtie));

`ifdef TRAP_SEQ_TIMEOUT_EN
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MAX - 1);
    logic [3:0] drain_cnt;
    logic       drain_expired;

    assign drain_expired = (drain_cnt == DRAIN_LAST);

    // Count consecutive bubble cycles spent waiting in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (state != DRAIN) begin
            drain_cnt <= '0;
        end else if (!mw_valid && !drain_expired) begin
            drain_cnt <= drain_cnt + 4'd1;
        end
    end
`else
    logic unused_drain;
    assign unused_drain = ^{pc_de, 4'(DRAIN_MAX)};
`endif

    // State register, gap counter and the latched mepc/mcause values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            mepc_out   <= '0;
            mcause_out <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (!is_mret_mw && irq_pend) begin
                        mcause_out <= ext_pend ? CAUSE_EXT : CAUSE_TIMER;
                    end
                end
                DRAIN: begin
                    if (mw_valid) begin
                        mepc_out <= br_taken ? br_target : pc_mw + 32'd4;
                    end
`ifdef TRAP_SEQ_TIMEOUT_EN
                    else if (drain_expired) begin
                        mepc_out <= pc_de;
                    end
`endif
                end
                ENTER, EXIT: gap_cnt <= GAP_LOAD;
                GAP:         gap_cnt <= gap_cnt - 4'd1;
                default:     gap_cnt <= '0;
            endcase
        end
    end

    // Next-state decode and control outputs from state plus br_taken.
    always_comb begin
        state_nxt   = state;
        stall_f     = 1'b0;
        flush_de    = 1'b0;
        flush_mw    = 1'b0;
        pc_sel      = 2'd0;
        csr_trap_we = 1'b0;
        csr_mret_we = 1'b0;
        trap_taken  = 1'b0;
        case (state)
            IDLE: begin
                if (br_taken) begin
                    flush_de = 1'b1;
                    pc_sel   = 2'd1;
                end
                if (is_mret_mw) begin
                    state_nxt = EXIT;
                end else if (irq_pend) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                stall_f = 1'b1;
                if (mw_valid) begin
                    state_nxt = ENTER;
                end
`ifdef TRAP_SEQ_TIMEOUT_EN
                else if (drain_expired) begin
                    state_nxt = ENTER;
                end
`endif
            end
            ENTER: begin
                csr_trap_we = 1'b1;
                trap_taken  = 1'b1;
                pc_sel      = 2'd2;
                flush_de    = 1'b1;
                flush_mw    = 1'b1;
                state_nxt   = GAP;
            end
            EXIT: begin
                csr_mret_we = 1'b1;
                pc_sel      = 2'd3;
                flush_de    = 1'b1;
                state_nxt   = GAP;
            end
            GAP: begin
                if (br_taken) begin
                    flush_de = 1'b1;
                    pc_sel   = 2'd1;
                end
                if (gap_cnt <= 4'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
